// File: rtl/spi_frame_pkg.sv
// Frame constants, FSM encoding and the CHK update step for spi_tx_frame_sched.
// Define SPI_FRAME_CRC8_EN to make CHK a CRC-8 (poly 0x07, init 0, MSB-first) instead of an XOR.
package spi_frame_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] NULL_HDR  = 8'hFF;
   localparam logic [7:0] PAD_BYTE  = 8'h00;
   localparam logic [3:0] HDR_TAG   = 4'hC;
   localparam logic [7:0] CRC8_POLY = 8'h07;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_LEN  = 3'd2,
      ST_PAY  = 3'd3,
      ST_CHK  = 3'd4,
      ST_PAD  = 3'd5
   } state_t;

   function automatic logic [7:0] chk_upd(input logic [7:0] i_chk, input logic [7:0] i_dat);
      logic [7:0] w_c;
      w_c = i_chk ^ i_dat;
`ifdef SPI_FRAME_CRC8_EN
      for (int b = 0; b < 8; b++) begin
         w_c = w_c[7] ? ((w_c << 1) ^ CRC8_POLY) : (w_c << 1);
      end
`endif
      return w_c;
   endfunction

endpackage

// File: rtl/spi_tx_frame_sched_rr_pick.sv
// Combinational round-robin pick: first requester at or after i_ptr, wrapping modulo N_CH.
// No latency, no flow control.
module rr_pick #(
   parameter int N_CH = 4,
   parameter int CW   = 2
) (
   input  logic [N_CH-1:0] i_req,
   input  logic [CW-1:0]   i_ptr,
   output logic [CW-1:0]   o_idx,
   output logic            o_vld
);

   logic [2*N_CH-1:0] w_dbl;
   int                w_sum;

   always_comb begin
      o_idx = '0;
      o_vld = 1'b0;
      w_sum = 0;
      w_dbl = {i_req, i_req} >> i_ptr;
      // Scan from the far end so the smallest offset from the pointer wins.
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (w_dbl[k]) begin
            o_vld = 1'b1;
            w_sum = int'(i_ptr) + k;
            o_idx = CW'((w_sum >= N_CH) ? (w_sum - N_CH) : w_sum);
         end
      end
   end

endmodule

// File: rtl/spi_tx_frame_sched.sv
// Frames round-robin channel FIFO bytes (sync, hdr, len, payload, chk, pad) for the SPI MISO byte source.
// Next byte within 2 clk_sys of req_rd; req_rd is the only flow control. CHK is CRC-8 with SPI_FRAME_CRC8_EN.
module spi_tx_frame_sched
   import spi_frame_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int LW      = 8,
   parameter int MAX_PAY = 32
) (
   input  logic               clk_sys,
   input  logic               rst_n,
   input  logic               i_spi_csn_real,
   input  logic               i_req_rd,
   output logic [7:0]         o_req_q,
   input  logic [N_CH*8-1:0]  i_src_q,
   input  logic [N_CH*LW-1:0] i_src_level,
   output logic [N_CH-1:0]    o_src_rd,
   output logic               o_frame_done,
   output logic               o_frame_abort
);

   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

   state_t          r_state, w_state_nxt;
   logic            r_armed, w_armed_nxt;
   logic            r_null, w_null_nxt;
   logic [CW-1:0]   r_ch, w_ch_nxt;
   logic [CW-1:0]   r_ptr, w_ptr_nxt;
   logic [7:0]      r_len, w_len_nxt;
   logic [7:0]      r_cnt, w_cnt_nxt;
   logic [7:0]      r_chk, w_chk_nxt;
   logic [7:0]      r_byte, w_byte_nxt;
   logic [N_CH-1:0] r_src_rd, w_src_rd_nxt;
   logic            r_done, w_done_nxt;
   logic            r_abort, w_abort_nxt;

   logic [N_CH-1:0] w_req;
   logic [CW-1:0]   w_gnt;
   logic            w_gnt_vld;
   logic [LW-1:0]   w_gnt_lvl;
   logic [7:0]      w_gnt_len;
   logic [7:0]      w_pay;

   always_comb begin
      w_req     = '0;
      w_gnt_lvl = '0;
      w_pay     = '0;
      for (int i = 0; i < N_CH; i++) begin
         w_req[i] = |i_src_level[i*LW +: LW];
         if (w_gnt == CW'(i)) w_gnt_lvl = i_src_level[i*LW +: LW];
         if (r_ch == CW'(i))  w_pay     = i_src_q[i*8 +: 8];
      end
      w_gnt_len = (int'(w_gnt_lvl) > MAX_PAY) ? 8'(MAX_PAY) : 8'(w_gnt_lvl);
   end

   rr_pick #(.N_CH(N_CH), .CW(CW)) u_rr_pick (
      .i_req (w_req),
      .i_ptr (r_ptr),
      .o_idx (w_gnt),
      .o_vld (w_gnt_vld)
   );

   // Payload bytes come straight from the show-ahead head so the post-pop byte is visible in time.
   assign o_req_q       = (r_state == ST_PAY) ? w_pay : r_byte;
   assign o_src_rd      = r_src_rd;
   assign o_frame_done  = r_done;
   assign o_frame_abort = r_abort;

   always_comb begin
      w_state_nxt  = r_state;
      w_armed_nxt  = r_armed;
      w_null_nxt   = r_null;
      w_ch_nxt     = r_ch;
      w_ptr_nxt    = r_ptr;
      w_len_nxt    = r_len;
      w_cnt_nxt    = r_cnt;
      w_chk_nxt    = r_chk;
      w_byte_nxt   = r_byte;
      w_src_rd_nxt = '0;
      w_done_nxt   = 1'b0;
      w_abort_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_byte_nxt = SYNC_BYTE;
            if (i_spi_csn_real) begin
               w_armed_nxt = 1'b0;
            end else begin
               // Grant once per chip-select assertion, while sync is still on the wire.
               if (!r_armed) begin
                  w_armed_nxt = 1'b1;
                  w_chk_nxt   = '0;
                  if (w_gnt_vld) begin
                     w_null_nxt = 1'b0;
                     w_ch_nxt   = w_gnt;
                     w_len_nxt  = w_gnt_len;
                     w_ptr_nxt  = (w_gnt == CW'(N_CH - 1)) ? '0 : w_gnt + 1'b1;
                  end else begin
                     w_null_nxt = 1'b1;
                     w_len_nxt  = '0;
                  end
               end
               if (i_req_rd) begin
                  w_state_nxt = ST_HDR;
                  w_armed_nxt = 1'b0;
                  w_byte_nxt  = w_null_nxt ? NULL_HDR : {HDR_TAG, 1'b0, 3'(w_ch_nxt)};
               end
            end
         end
         ST_PAD: begin
            if (i_spi_csn_real) begin
               w_state_nxt = ST_IDLE;
               w_byte_nxt  = SYNC_BYTE;
            end
         end
         default: begin
            if (i_spi_csn_real) begin
               w_abort_nxt = 1'b1;
               w_state_nxt = ST_IDLE;
               w_byte_nxt  = SYNC_BYTE;
            end else if (i_req_rd) begin
               case (r_state)
                  ST_HDR: begin
                     w_chk_nxt   = chk_upd(r_chk, r_byte);
                     w_byte_nxt  = r_len;
                     w_state_nxt = ST_LEN;
                  end
                  ST_LEN: begin
                     w_chk_nxt = chk_upd(r_chk, r_len);
                     if (r_len == 8'd0) begin
                        w_state_nxt = ST_CHK;
                        w_byte_nxt  = w_chk_nxt;
                     end else begin
                        w_state_nxt = ST_PAY;
                        w_cnt_nxt   = r_len;
                     end
                  end
                  ST_PAY: begin
                     w_chk_nxt    = chk_upd(r_chk, w_pay);
                     w_src_rd_nxt = N_CH'(1) << r_ch;
                     w_cnt_nxt    = r_cnt - 1'b1;
                     if (r_cnt == 8'd1) begin
                        w_state_nxt = ST_CHK;
                        w_byte_nxt  = w_chk_nxt;
                     end
                  end
                  ST_CHK: begin
                     w_done_nxt  = 1'b1;
                     w_state_nxt = ST_PAD;
                     w_byte_nxt  = PAD_BYTE;
                  end
                  default: w_state_nxt = ST_IDLE;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_armed  <= 1'b0;
         r_null   <= 1'b0;
         r_ch     <= '0;
         r_ptr    <= '0;
         r_len    <= '0;
         r_cnt    <= '0;
         r_chk    <= '0;
         r_byte   <= SYNC_BYTE;
         r_src_rd <= '0;
         r_done   <= 1'b0;
         r_abort  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_armed  <= w_armed_nxt;
         r_null   <= w_null_nxt;
         r_ch     <= w_ch_nxt;
         r_ptr    <= w_ptr_nxt;
         r_len    <= w_len_nxt;
         r_cnt    <= w_cnt_nxt;
         r_chk    <= w_chk_nxt;
         r_byte   <= w_byte_nxt;
         r_src_rd <= w_src_rd_nxt;
         r_done   <= w_done_nxt;
         r_abort  <= w_abort_nxt;
      end
   end

endmodule

// File: tb/tb_spi_tx_frame_sched.sv
// Bench for spi_tx_frame_sched: show-ahead FIFO models, frame scoreboard, 2-cycle byte latency checks.
module tb_spi_tx_frame_sched;

   logic        clk_sys = 1'b0;
   logic        rst_n;
   logic        spi_csn_real;
   logic        req_rd;
   logic [7:0]  req_q;
   logic [31:0] src_q;
   logic [31:0] src_level;
   logic [3:0]  src_rd;
   logic        frame_done;
   logic        frame_abort;

   logic [7:0]  fq[4][$];
   logic [7:0]  exp_q[$];
   logic [3:0]  pend;
   int          pops[4];
   int          n_done, n_abort, n_chk, n_err, m_ptr;
   int          d0, a0, p0;

   always #5 clk_sys = ~clk_sys;

   spi_tx_frame_sched #(.N_CH(4), .LW(8), .MAX_PAY(32)) dut (
      .clk_sys        (clk_sys),
      .rst_n          (rst_n),
      .i_spi_csn_real (spi_csn_real),
      .i_req_rd       (req_rd),
      .o_req_q        (req_q),
      .i_src_q        (src_q),
      .i_src_level    (src_level),
      .o_src_rd       (src_rd),
      .o_frame_done   (frame_done),
      .o_frame_abort  (frame_abort)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Reference CHK step: bit-serial CRC-8 (feedback per message bit) or plain XOR.
   function automatic logic [7:0] ref_upd(input logic [7:0] c, input logic [7:0] d);
      logic [7:0] r;
      r = c;
`ifdef SPI_FRAME_CRC8_EN
      for (int b = 7; b >= 0; b--) begin
         logic fb;
         fb = r[7] ^ d[b];
         r  = {r[6:0], 1'b0};
         if (fb) r = r ^ 8'h07;
      end
`else
      r = r ^ d;
`endif
      return r;
   endfunction

   task automatic drive_src();
      for (int i = 0; i < 4; i++) begin
         src_q[i*8 +: 8]     = (fq[i].size() != 0) ? fq[i][0] : 8'h00;
         src_level[i*8 +: 8] = 8'((fq[i].size() > 255) ? 255 : fq[i].size());
      end
   endtask

   // One clock: apply pops strobed last cycle just after the edge, then sample outputs at the falling edge.
   task automatic cyc();
      @(posedge clk_sys);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (pend[i]) begin
            if (fq[i].size() != 0) void'(fq[i].pop_front());
            pops[i]++;
         end
      end
      pend = '0;
      drive_src();
      @(negedge clk_sys);
      pend = src_rd;
      if (frame_done)  n_done++;
      if (frame_abort) n_abort++;
   endtask

   task automatic load(input int ch, input int n, input logic [7:0] base, input logic [7:0] step);
      for (int k = 0; k < n; k++) fq[ch].push_back(base + 8'(k) * step);
      drive_src();
   endtask

   task automatic build_frame();
      int         ch;
      logic [7:0] hdr, len, c;
      ch = -1;
      for (int k = 0; k < 4; k++) begin
         if (ch < 0 && fq[(m_ptr + k) % 4].size() != 0) ch = (m_ptr + k) % 4;
      end
      exp_q.delete();
      if (ch < 0) begin
         hdr = 8'hFF;
         len = 8'h00;
      end else begin
         hdr   = 8'hC0 | 8'(ch);
         len   = 8'((fq[ch].size() > 32) ? 32 : fq[ch].size());
         m_ptr = (ch + 1) % 4;
      end
      c = ref_upd(8'h00, hdr);
      c = ref_upd(c, len);
      exp_q.push_back(8'hA5);
      exp_q.push_back(hdr);
      exp_q.push_back(len);
      for (int k = 0; k < int'(len); k++) begin
         exp_q.push_back(fq[ch][k]);
         c = ref_upd(c, fq[ch][k]);
      end
      exp_q.push_back(c);
      exp_q.push_back(8'h00);
   endtask

   task automatic cs_fall();
      spi_csn_real = 1'b0;
      build_frame();
      cyc();
      cyc();
      check("sync", req_q, exp_q.pop_front());
   endtask

   task automatic rd();
      logic [7:0] e;
      req_rd = 1'b1;
      cyc();
      req_rd = 1'b0;
      cyc();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      check("byte_lat2", req_q, e);
      cyc();
      cyc();
      check("byte_hold", req_q, e);
   endtask

   task automatic cs_rise();
      spi_csn_real = 1'b1;
      cyc();
      cyc();
      exp_q.delete();
      check("idle_sync", req_q, 8'hA5);
   endtask

   function automatic int pop_sum();
      return pops[0] + pops[1] + pops[2] + pops[3];
   endfunction

   initial begin
      rst_n = 1'b0; spi_csn_real = 1'b1; req_rd = 1'b0;
      src_q = '0; src_level = '0; pend = '0;
      n_done = 0; n_abort = 0; n_chk = 0; n_err = 0; m_ptr = 0;
      for (int i = 0; i < 4; i++) pops[i] = 0;
      drive_src();
      repeat (3) cyc();
      rst_n = 1'b1;
      cyc();
      check("rst_req_q", req_q, 8'hA5);
      check("rst_src_rd", src_rd, 4'h0);
      check("rst_done", frame_done, 1'b0);
      check("rst_abort", frame_abort, 1'b0);

      // Null frame: nothing queued anywhere.
      d0 = n_done; p0 = pop_sum();
      cs_fall();
      repeat (6) rd();
      check("null_done", n_done - d0, 1);
      check("null_pops", pop_sum() - p0, 0);
      cs_rise();

      // Single channel 2 with 11,22,33.
      load(2, 3, 8'h11, 8'h11);
      d0 = n_done; p0 = pops[2];
      cs_fall();
      repeat (7) rd();
      check("ch2_done", n_done - d0, 1);
      check("ch2_pops", pops[2] - p0, 3);
      cs_rise();

      // Pointer now 3: ch3 must win over ch0.
      load(0, 1, 8'h5A, 8'h00);
      load(3, 2, 8'h3C, 8'h11);
      cs_fall();
      repeat (6) rd();
      cs_rise();

      // ch0 and ch1 at level 40: two MAX_PAY frames.
      load(0, 39, 8'h80, 8'h01);
      load(1, 40, 8'h40, 8'h01);
      d0 = n_done;
      cs_fall();
      repeat (36) rd();
      cs_rise();
      cs_fall();
      repeat (36) rd();
      cs_rise();
      check("maxpay_done", n_done - d0, 2);
      check("ch0_level_left", src_level[7:0], 8'd8);

      // Abort after two payload bytes of a 5-byte ch2 frame.
      load(2, 5, 8'hD0, 8'h01);
      load(3, 2, 8'hA1, 8'h11);
      a0 = n_abort; p0 = pops[2];
      cs_fall();
      repeat (5) rd();
      cs_rise();
      check("abort_pulse", n_abort - a0, 1);
      check("abort_pops", pops[2] - p0, 2);

      // Next grant is ch3; req_rd and CS rise together in PAY: abort, no pop.
      a0 = n_abort; p0 = pops[3];
      cs_fall();
      repeat (3) rd();
      req_rd = 1'b1; spi_csn_real = 1'b1;
      cyc();
      req_rd = 1'b0;
      cyc();
      cyc();
      exp_q.delete();
      check("same_cyc_abort", n_abort - a0, 1);
      check("same_cyc_pops", pops[3] - p0, 0);
      check("same_cyc_sync", req_q, 8'hA5);

      // req_rd with CS high is ignored.
      d0 = n_done; a0 = n_abort; p0 = pop_sum();
      repeat (3) begin
         req_rd = 1'b1;
         cyc();
         req_rd = 1'b0;
         cyc();
      end
      check("cs_hi_q", req_q, 8'hA5);
      check("cs_hi_done", n_done - d0, 0);
      check("cs_hi_abort", n_abort - a0, 0);
      check("cs_hi_pops", pop_sum() - p0, 0);

      // Remaining 8 bytes of ch0 in a normal frame.
      d0 = n_done; p0 = pops[0];
      cs_fall();
      repeat (12) rd();
      check("ch0_tail_done", n_done - d0, 1);
      check("ch0_tail_pops", pops[0] - p0, 8);
      cs_rise();

      // Reset while a ch1 pop strobe is high.
      cs_fall();
      repeat (3) rd();
      req_rd = 1'b1;
      @(posedge clk_sys);
      #1;
      check("pre_rst_src_rd", src_rd, 4'b0010);
      rst_n = 1'b0;
      #1;
      check("mid_rst_src_rd", src_rd, 4'h0);
      check("mid_rst_req_q", req_q, 8'hA5);
      req_rd = 1'b0;
      spi_csn_real = 1'b1;
      @(negedge clk_sys);
      rst_n = 1'b1;
      pend = '0;
      cyc();
      check("post_rst_abort", frame_abort, 1'b0);
      check("post_rst_q", req_q, 8'hA5);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
